// File: rtl/forward_hazard_unit_if.sv
// forward_hazard_unit_if
//   Groups the pipeline-hazard signals exchanged with forward_hazard_unit.
//   master : pipeline side (drives register addresses/flags, receives controls)
//   slave  : hazard unit side
// Signals:
//   id_src/idex_src          source register addresses, operand i at [i*REG_AW +: REG_AW]
//   id_src_vld/idex_src_vld  per-operand "register is read" flags
//   idex/exmem/memwb_dst     destination register per stage
//   *_regwr, *_memrd         per-stage register-write enable and load flag
//   flush                    squash of IF/ID and ID/EX
//   fwd_sel                  per-operand forward select (2 bits each)
//   stall, bubble            hold PC/IF-ID, insert NOP into ID/EX
//   stall_cnt                stall cycle counter
interface forward_hazard_unit_if #(
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC*REG_AW-1:0] idex_src;
  logic [NUM_SRC-1:0]        id_src_vld;
  logic [NUM_SRC-1:0]        idex_src_vld;
  logic [REG_AW-1:0]         idex_dst;
  logic [REG_AW-1:0]         exmem_dst;
  logic [REG_AW-1:0]         memwb_dst;
  logic                      idex_regwr;
  logic                      exmem_regwr;
  logic                      memwb_regwr;
  logic                      idex_memrd;
  logic                      exmem_memrd;
  logic                      memwb_memrd;
  logic                      flush;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_src, idex_src, id_src_vld, idex_src_vld,
           idex_dst, exmem_dst, memwb_dst,
           idex_regwr, exmem_regwr, memwb_regwr,
           idex_memrd, exmem_memrd, memwb_memrd, flush,
    input  fwd_sel, stall, bubble, stall_cnt
  );

  modport slave (
    input  id_src, idex_src, id_src_vld, idex_src_vld,
           idex_dst, exmem_dst, memwb_dst,
           idex_regwr, exmem_regwr, memwb_regwr,
           idex_memrd, exmem_memrd, memwb_memrd, flush,
    output fwd_sel, stall, bubble, stall_cnt
  );
endinterface

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//   Operand forwarding select and load-use stall control for a 5-stage pipeline.
//   fwd_sel is purely combinational. A load-use hazard produces LU_STALL
//   consecutive stall+bubble cycles; flush cancels any stall immediately.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  forward_hazard_unit_if.slave (see interface file for signal list)
// Optional feature:
//   FWD_PERF_CNT_EN defined   -> saturating stall cycle counter on stall_cnt
//   FWD_PERF_CNT_EN undefined -> stall_cnt tied to zero, no counter flops
module forward_hazard_unit #(
  parameter int REG_AW   = 3,
  parameter int NUM_SRC  = 2,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  forward_hazard_unit_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_rem;
  logic [2:0]           w_rem_nxt;
  logic                 w_hazard;
  logic                 w_stall;
  logic                 w_bubble;
  logic [2*NUM_SRC-1:0] w_fwd_sel;

  // Youngest producer first; an EX/MEM load never forwards and falls
  // through to the MEM/WB checks.
  always_comb begin
    w_fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.idex_src_vld[i] && bus.exmem_regwr && !bus.exmem_memrd &&
          bus.idex_src[i*REG_AW +: REG_AW] == bus.exmem_dst)
        w_fwd_sel[2*i +: 2] = 2'b10;
      else if (bus.idex_src_vld[i] && bus.memwb_regwr && bus.memwb_memrd &&
               bus.idex_src[i*REG_AW +: REG_AW] == bus.memwb_dst)
        w_fwd_sel[2*i +: 2] = 2'b11;
      else if (bus.idex_src_vld[i] && bus.memwb_regwr && !bus.memwb_memrd &&
               bus.idex_src[i*REG_AW +: REG_AW] == bus.memwb_dst)
        w_fwd_sel[2*i +: 2] = 2'b01;
    end
    if (rst)
      w_fwd_sel = '0;
  end

  always_comb begin
    w_hazard = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_vld[i] && bus.id_src[i*REG_AW +: REG_AW] == bus.idex_dst)
        w_hazard = 1'b1;
    end
    if (!(bus.idex_memrd && bus.idex_regwr))
      w_hazard = 1'b0;
  end

  // The IDLE hazard cycle is the first stall cycle, so STALL only covers
  // the remaining LU_STALL-1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    if (bus.flush) begin
      w_bubble    = 1'b1;
      w_state_nxt = IDLE;
      w_rem_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hazard) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (LU_STALL > 1) begin
              w_state_nxt = STALL;
              w_rem_nxt   = 3'(LU_STALL - 1);
            end
          end
        end
        STALL: begin
          w_stall   = 1'b1;
          w_bubble  = 1'b1;
          w_rem_nxt = r_rem - 3'd1;
          if (r_rem <= 3'd1) begin
            w_state_nxt = IDLE;
            w_rem_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_rem_nxt   = '0;
        end
      endcase
    end
    if (rst) begin
      w_state_nxt = IDLE;
      w_rem_nxt   = '0;
      w_stall     = 1'b0;
      w_bubble    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  assign bus.fwd_sel = w_fwd_sel;
  assign bus.stall   = w_stall;
  assign bus.bubble  = w_bubble;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef FWD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  forward_hazard_unit_if #(.REG_AW(3), .NUM_SRC(2), .CNT_W(4))  bus_a ();
  forward_hazard_unit_if #(.REG_AW(3), .NUM_SRC(2), .CNT_W(16)) bus_b ();

  forward_hazard_unit #(.REG_AW(3), .NUM_SRC(2), .LU_STALL(3), .CNT_W(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  forward_hazard_unit #(.REG_AW(3), .NUM_SRC(2), .LU_STALL(4), .CNT_W(16)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // src pairs written in octal: {operand1, operand0}
  typedef struct {
    logic [5:0] id_src;
    logic [1:0] id_vld;
    logic [5:0] idex_src;
    logic [1:0] idex_vld;
    logic [2:0] idex_dst;
    logic [2:0] exmem_dst;
    logic [2:0] memwb_dst;
    logic [2:0] regwr;   // {idex, exmem, memwb}
    logic [2:0] memrd;   // {idex, exmem, memwb}
    logic [3:0] exp_fwd;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[16];

  task automatic idle_a();
    bus_a.id_src = '0;       bus_a.idex_src = '0;
    bus_a.id_src_vld = '0;   bus_a.idex_src_vld = '0;
    bus_a.idex_dst = '0;     bus_a.exmem_dst = '0;   bus_a.memwb_dst = '0;
    bus_a.idex_regwr = 1'b0; bus_a.exmem_regwr = 1'b0; bus_a.memwb_regwr = 1'b0;
    bus_a.idex_memrd = 1'b0; bus_a.exmem_memrd = 1'b0; bus_a.memwb_memrd = 1'b0;
    bus_a.flush = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.id_src = '0;       bus_b.idex_src = '0;
    bus_b.id_src_vld = '0;   bus_b.idex_src_vld = '0;
    bus_b.idex_dst = '0;     bus_b.exmem_dst = '0;   bus_b.memwb_dst = '0;
    bus_b.idex_regwr = 1'b0; bus_b.exmem_regwr = 1'b0; bus_b.memwb_regwr = 1'b0;
    bus_b.idex_memrd = 1'b0; bus_b.exmem_memrd = 1'b0; bus_b.memwb_memrd = 1'b0;
    bus_b.flush = 1'b0;
  endtask

  // load to R2 in ID/EX while ID reads R2 as operand 0
  task automatic hazard_a();
    bus_a.idex_dst = 3'd2; bus_a.idex_regwr = 1'b1; bus_a.idex_memrd = 1'b1;
    bus_a.id_src = 6'o02;  bus_a.id_src_vld = 2'b01;
  endtask

  task automatic hazard_b();
    bus_b.idex_dst = 3'd2; bus_b.idex_regwr = 1'b1; bus_b.idex_memrd = 1'b1;
    bus_b.id_src = 6'o02;  bus_b.id_src_vld = 2'b01;
  endtask

  task automatic apply(input vec_t v);
    bus_a.id_src       = v.id_src;
    bus_a.id_src_vld   = v.id_vld;
    bus_a.idex_src     = v.idex_src;
    bus_a.idex_src_vld = v.idex_vld;
    bus_a.idex_dst     = v.idex_dst;
    bus_a.exmem_dst    = v.exmem_dst;
    bus_a.memwb_dst    = v.memwb_dst;
    {bus_a.idex_regwr, bus_a.exmem_regwr, bus_a.memwb_regwr} = v.regwr;
    {bus_a.idex_memrd, bus_a.exmem_memrd, bus_a.memwb_memrd} = v.memrd;
    bus_a.flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    // forwarding cases
    vecs[0]  = '{6'o00, 2'b00, 6'o33, 2'b11, 3'd0, 3'd3, 3'd3, 3'b011, 3'b000, 4'b1010, 1'b0};
    vecs[1]  = '{6'o00, 2'b00, 6'o51, 2'b11, 3'd0, 3'd0, 3'd5, 3'b001, 3'b001, 4'b1100, 1'b0};
    vecs[2]  = '{6'o00, 2'b00, 6'o22, 2'b01, 3'd0, 3'd0, 3'd2, 3'b001, 3'b000, 4'b0001, 1'b0};
    vecs[3]  = '{6'o00, 2'b00, 6'o04, 2'b11, 3'd0, 3'd4, 3'd4, 3'b011, 3'b010, 4'b0001, 1'b0};
    vecs[4]  = '{6'o00, 2'b00, 6'o66, 2'b11, 3'd0, 3'd6, 3'd0, 3'b010, 3'b010, 4'b0000, 1'b0};
    vecs[5]  = '{6'o00, 2'b00, 6'o77, 2'b11, 3'd0, 3'd7, 3'd7, 3'b000, 3'b001, 4'b0000, 1'b0};
    vecs[6]  = '{6'o00, 2'b00, 6'o12, 2'b11, 3'd0, 3'd1, 3'd2, 3'b011, 3'b001, 4'b1011, 1'b0};
    vecs[7]  = '{6'o00, 2'b00, 6'o50, 2'b11, 3'd0, 3'd5, 3'd5, 3'b011, 3'b001, 4'b1000, 1'b0};
    vecs[8]  = '{6'o00, 2'b00, 6'o33, 2'b01, 3'd0, 3'd3, 3'd0, 3'b010, 3'b000, 4'b0010, 1'b0};
    // load-use detection
    vecs[9]  = '{6'o02, 2'b01, 6'o00, 2'b00, 3'd2, 3'd0, 3'd0, 3'b100, 3'b100, 4'b0000, 1'b1};
    vecs[10] = '{6'o30, 2'b10, 6'o00, 2'b00, 3'd3, 3'd0, 3'd0, 3'b100, 3'b100, 4'b0000, 1'b1};
    vecs[11] = '{6'o22, 2'b00, 6'o00, 2'b00, 3'd2, 3'd0, 3'd0, 3'b100, 3'b100, 4'b0000, 1'b0};
    vecs[12] = '{6'o02, 2'b01, 6'o00, 2'b00, 3'd2, 3'd0, 3'd0, 3'b100, 3'b000, 4'b0000, 1'b0};
    vecs[13] = '{6'o02, 2'b01, 6'o00, 2'b00, 3'd2, 3'd0, 3'd0, 3'b000, 3'b100, 4'b0000, 1'b0};
    vecs[14] = '{6'o00, 2'b11, 6'o00, 2'b00, 3'd0, 3'd0, 3'd0, 3'b100, 3'b100, 4'b0000, 1'b1};
    vecs[15] = '{6'o12, 2'b11, 6'o00, 2'b00, 3'd3, 3'd0, 3'd0, 3'b100, 3'b100, 4'b0000, 1'b0};

    // reset with hazard, forward match and flush all active: outputs stay quiet
    rst = 1'b1;
    idle_a(); idle_b();
    hazard_a();
    bus_a.idex_src = 6'o33; bus_a.idex_src_vld = 2'b11;
    bus_a.exmem_regwr = 1'b1; bus_a.exmem_dst = 3'd3;
    hazard_b(); bus_b.flush = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_fwd_sel",  32'(bus_a.fwd_sel),   32'h0);
    check("rst_stall_a",  32'(bus_a.stall),     32'h0);
    check("rst_bubble_a", 32'(bus_a.bubble),    32'h0);
    check("rst_cnt_a",    32'(bus_a.stall_cnt), 32'h0);
    check("rst_bubble_b", 32'(bus_b.bubble),    32'h0);
    check("rst_cnt_b",    32'(bus_b.stall_cnt), 32'h0);
    idle_a(); idle_b();
    rst = 1'b0;

    // table: drive in the low phase, check, clear before the rising edge
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_fwd", i),    32'(bus_a.fwd_sel), 32'(vecs[i].exp_fwd));
      check($sformatf("vec%0d_stall", i),  32'(bus_a.stall),   32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_bubble", i), 32'(bus_a.bubble),  32'(vecs[i].exp_stall));
      idle_a();
    end

    // LU_STALL=3: hazard held throughout must not extend or reload the stall
    @(negedge clk);
    hazard_a();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 3) idle_a();
      #1;
      check($sformatf("lu3_stall_c%0d", c),  32'(bus_a.stall),  32'(c < 3));
      check($sformatf("lu3_bubble_c%0d", c), 32'(bus_a.bubble), 32'(c < 3));
    end
    check("lu3_cnt", 32'(bus_a.stall_cnt), PERF ? 32'd3 : 32'd0);

    // reset in the 2nd stall cycle aborts the stall
    @(negedge clk);
    hazard_a();
    #1;
    check("rstmid_first", 32'(bus_a.stall), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_a();
    #1;
    check("rstmid_stall",  32'(bus_a.stall),     32'h0);
    check("rstmid_bubble", 32'(bus_a.bubble),    32'h0);
    check("rstmid_cnt",    32'(bus_a.stall_cnt), 32'h0);

    // saturation of the 4-bit counter over 20+ stall cycles
    @(negedge clk);
    hazard_a();
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    check("sat_cnt10", 32'(bus_a.stall_cnt), PERF ? 32'd10 : 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    idle_a();
    #1;
    check("sat_cnt20", 32'(bus_a.stall_cnt), PERF ? 32'd15 : 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("sat_hold",  32'(bus_a.stall_cnt), PERF ? 32'd15 : 32'd0);
    check("sat_stall_end", 32'(bus_a.stall), 32'h0);

    // LU_STALL=4: flush in the 2nd stall cycle
    @(negedge clk);
    hazard_b();
    #1;
    check("fl_c1_stall",  32'(bus_b.stall),  32'h1);
    check("fl_c1_bubble", 32'(bus_b.bubble), 32'h1);
    @(negedge clk);
    bus_b.flush = 1'b1;
    #1;
    check("fl_c2_stall",  32'(bus_b.stall),  32'h0);
    check("fl_c2_bubble", 32'(bus_b.bubble), 32'h1);
    @(negedge clk);
    idle_b();
    #1;
    check("fl_c3_stall",  32'(bus_b.stall),  32'h0);
    check("fl_c3_bubble", 32'(bus_b.bubble), 32'h0);
    check("fl_cnt",       32'(bus_b.stall_cnt), PERF ? 32'd1 : 32'd0);

    // flush together with a fresh hazard in IDLE: no stall at all
    @(negedge clk);
    hazard_b();
    bus_b.flush = 1'b1;
    #1;
    check("flidle_stall",  32'(bus_b.stall),  32'h0);
    check("flidle_bubble", 32'(bus_b.bubble), 32'h1);
    @(negedge clk);
    idle_b();
    #1;
    check("flidle_next_stall", 32'(bus_b.stall), 32'h0);

    // LU_STALL=4: exactly four stall cycles
    @(negedge clk);
    hazard_b();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 4) idle_b();
      #1;
      check($sformatf("lu4_stall_c%0d", c), 32'(bus_b.stall), 32'(c < 4));
    end
    check("lu4_cnt", 32'(bus_b.stall_cnt), PERF ? 32'd5 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
